// File: rtl/param_regfile_if.sv
// Register-file port bundle: two read ports, one byte-masked write port
// and the bulk-clear handshake.
interface param_regfile_if #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 5
);
  logic [ADDR_BITS-1:0] ReadRegister1;
  logic [ADDR_BITS-1:0] ReadRegister2;
  logic [WIDTH-1:0]     ReadData1;
  logic [WIDTH-1:0]     ReadData2;
  logic [ADDR_BITS-1:0] WriteRegister;
  logic [WIDTH-1:0]     WriteData;
  logic [WIDTH/8-1:0]   ByteEnable;
  logic                 RegWrite;
  logic                 Clear;
  logic                 Busy;

  modport master (
    output ReadRegister1, ReadRegister2, WriteRegister, WriteData,
           ByteEnable, RegWrite, Clear,
    input  ReadData1, ReadData2, Busy
  );

  modport slave (
    input  ReadRegister1, ReadRegister2, WriteRegister, WriteData,
           ByteEnable, RegWrite, Clear,
    output ReadData1, ReadData2, Busy
  );
endinterface

// File: rtl/param_regfile.sv
// Architectural register file: 2 async read ports, 1 byte-masked sync write
// port, optional write-to-read bypass and a one-word-per-cycle bulk clear.
//
// state    | meaning
// IDLE     | normal read/write operation, Busy low
// CLEARING | zeroing mem[clr_cnt] each cycle, writes and bypass blocked
module param_regfile #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 5,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1
) (
  input logic             Clk,
  input logic             Reset_n,
  param_regfile_if.slave  bus
);
  localparam int DEPTH  = 2 ** ADDR_BITS;
  localparam int NBYTES = WIDTH / 8;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

  typedef enum logic {IDLE, CLEARING} state_t;

  state_t               state;
  logic                 busy;
  logic [ADDR_BITS-1:0] clr_cnt;
  logic [WIDTH-1:0]     mem [DEPTH];

  logic wr_zero_masked;
  logic wr_en;
  logic hit1;
  logic hit2;

  assign wr_zero_masked = (ZERO_REG != 0) && (bus.WriteRegister == '0);
  assign wr_en          = bus.RegWrite && !busy && !wr_zero_masked;
  assign hit1 = (BYPASS != 0) && bus.RegWrite && !busy &&
                (bus.WriteRegister == bus.ReadRegister1);
  assign hit2 = (BYPASS != 0) && bus.RegWrite && !busy &&
                (bus.WriteRegister == bus.ReadRegister2);

  function automatic logic [WIDTH-1:0] merge(
    input logic [WIDTH-1:0]  stored,
    input logic              hit,
    input logic [WIDTH-1:0]  wd,
    input logic [NBYTES-1:0] be
  );
    logic [WIDTH-1:0] d;
    d = stored;
    for (int b = 0; b < NBYTES; b++) begin
      if (hit && be[b]) d[8*b +: 8] = wd[8*b +: 8];
    end
    return d;
  endfunction

  // A masked zero register wins over the bypass path.
  assign bus.ReadData1 = ((ZERO_REG != 0) && (bus.ReadRegister1 == '0)) ? '0 :
                         merge(mem[bus.ReadRegister1], hit1, bus.WriteData, bus.ByteEnable);
  assign bus.ReadData2 = ((ZERO_REG != 0) && (bus.ReadRegister2 == '0)) ? '0 :
                         merge(mem[bus.ReadRegister2], hit2, bus.WriteData, bus.ByteEnable);
  assign bus.Busy = busy;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      clr_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_en) begin
            for (int b = 0; b < NBYTES; b++) begin
              if (bus.ByteEnable[b])
                mem[bus.WriteRegister][8*b +: 8] <= bus.WriteData[8*b +: 8];
            end
          end
          if (bus.Clear) begin
            state   <= CLEARING;
            busy    <= 1'b1;
            clr_cnt <= '0;
          end
        end
        CLEARING: begin
          mem[clr_cnt] <= '0;
          if (clr_cnt == LAST_ADDR) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_param_regfile.sv
// Directed bench for param_regfile: default 32x32 instance plus a
// 16-bit x 8 instance with ZERO_REG=0 and BYPASS=0.
module tb_param_regfile;
  logic Clk;
  logic Reset_n;
  int   n_cmp;
  int   n_err;

  param_regfile_if #(.WIDTH(32), .ADDR_BITS(5)) ifa ();
  param_regfile_if #(.WIDTH(16), .ADDR_BITS(3)) ifb ();

  param_regfile #(.WIDTH(32), .ADDR_BITS(5), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .Clk(Clk), .Reset_n(Reset_n), .bus(ifa.slave));
  param_regfile #(.WIDTH(16), .ADDR_BITS(3), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .Clk(Clk), .Reset_n(Reset_n), .bus(ifb.slave));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        we;
    logic [4:0]  ra;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr_a(input logic [4:0] wa, input logic [31:0] wd, input logic [3:0] be);
    @(negedge Clk);
    ifa.WriteRegister = wa;
    ifa.WriteData     = wd;
    ifa.ByteEnable    = be;
    ifa.RegWrite      = 1'b1;
    @(posedge Clk);
    #1 ifa.RegWrite   = 1'b0;
  endtask

  task automatic wr_b(input logic [2:0] wa, input logic [15:0] wd);
    @(negedge Clk);
    ifb.WriteRegister = wa;
    ifb.WriteData     = wd;
    ifb.ByteEnable    = 2'b11;
    ifb.RegWrite      = 1'b1;
    @(posedge Clk);
    #1 ifb.RegWrite   = 1'b0;
  endtask

  initial begin
    int k;
    int busy_cnt;
    n_cmp = 0;
    n_err = 0;
    vecs[0] = '{5'd5, 32'hDEADBEEF, 4'hF, 1'b0, 5'd5, 32'h0000_0000};
    vecs[1] = '{5'd5, 32'hDEADBEEF, 4'hF, 1'b1, 5'd5, 32'hDEADBEEF};
    vecs[2] = '{5'd7, 32'h11223344, 4'hF, 1'b1, 5'd7, 32'h11223344};
    vecs[3] = '{5'd7, 32'hAABBCCDD, 4'h5, 1'b1, 5'd7, 32'h11BB33DD};
    vecs[4] = '{5'd0, 32'hFFFFFFFF, 4'hF, 1'b1, 5'd0, 32'h0000_0000};
    vecs[5] = '{5'd7, 32'hFFFFFFFF, 4'h0, 1'b1, 5'd7, 32'h11BB33DD};
    vecs[6] = '{5'd3, 32'h0000_0001, 4'hF, 1'b1, 5'd3, 32'h0000_0001};
    vecs[7] = '{5'd9, 32'hCAFEF00D, 4'hA, 1'b1, 5'd9, 32'hCA00F000};
    vecs[8] = '{5'd5, 32'h0000_0000, 4'hF, 1'b0, 5'd5, 32'hDEADBEEF};

    Reset_n = 1'b0;
    ifa.ReadRegister1 = '0; ifa.ReadRegister2 = '0; ifa.WriteRegister = '0;
    ifa.WriteData = '0; ifa.ByteEnable = '0; ifa.RegWrite = 1'b0; ifa.Clear = 1'b0;
    ifb.ReadRegister1 = '0; ifb.ReadRegister2 = '0; ifb.WriteRegister = '0;
    ifb.WriteData = '0; ifb.ByteEnable = '0; ifb.RegWrite = 1'b0; ifb.Clear = 1'b0;

    repeat (2) @(posedge Clk);
    #1 chk("reset_busy", {31'd0, ifa.Busy}, 32'd0);
    for (int i = 0; i < 32; i += 4) begin
      ifa.ReadRegister1 = 5'(i);
      #1 chk("reset_read", ifa.ReadData1, 32'd0);
    end
    @(negedge Clk) Reset_n = 1'b1;

    // Table of single-write vectors, checked on both ports after the edge.
    for (int v = 0; v < 9; v++) begin
      @(negedge Clk);
      ifa.WriteRegister = vecs[v].wa;
      ifa.WriteData     = vecs[v].wd;
      ifa.ByteEnable    = vecs[v].be;
      ifa.RegWrite      = vecs[v].we;
      @(posedge Clk);
      #1 ifa.RegWrite   = 1'b0;
      ifa.ReadRegister1 = vecs[v].ra;
      ifa.ReadRegister2 = vecs[v].ra;
      #1;
      chk($sformatf("vec%0d_p1", v), ifa.ReadData1, vecs[v].exp);
      chk($sformatf("vec%0d_p2", v), ifa.ReadData2, vecs[v].exp);
    end

    // Bypass: r3 holds 1, same-cycle write must be visible before the edge.
    @(negedge Clk);
    ifa.WriteRegister = 5'd3; ifa.WriteData = 32'h12345678; ifa.ByteEnable = 4'hF;
    ifa.RegWrite = 1'b1; ifa.ReadRegister1 = 5'd3; ifa.ReadRegister2 = 5'd3;
    #1 chk("byp_p1", ifa.ReadData1, 32'h12345678);
    chk("byp_p2", ifa.ReadData2, 32'h12345678);
    @(posedge Clk);
    #1 ifa.RegWrite = 1'b0;
    #1 chk("byp_after", ifa.ReadData1, 32'h12345678);
    @(negedge Clk);
    ifa.WriteData = 32'hAAAAAAAA; ifa.ByteEnable = 4'b0011; ifa.RegWrite = 1'b1;
    ifa.ReadRegister2 = 5'd0; ifa.WriteRegister = 5'd3;
    #1 chk("byp_merge", ifa.ReadData1, 32'h1234AAAA);
    ifa.WriteRegister = 5'd0;
    #1 chk("byp_zero", ifa.ReadData2, 32'd0);
    ifa.RegWrite = 1'b0;

    // Bulk clear with r1..r31 = index; a write to r9 shares the start edge.
    for (int i = 1; i < 32; i++) wr_a(5'(i), 32'(i), 4'hF);
    @(negedge Clk);
    ifa.Clear = 1'b1; ifa.RegWrite = 1'b1; ifa.WriteRegister = 5'd9;
    ifa.WriteData = 32'h77; ifa.ByteEnable = 4'hF;
    ifa.ReadRegister1 = 5'd20; ifa.ReadRegister2 = 5'd9;
    @(posedge Clk);
    #1 ifa.Clear = 1'b0;
    ifa.RegWrite = 1'b0;
    k = 0;
    busy_cnt = 0;
    while (ifa.Busy && k < 100) begin
      busy_cnt++;
      chk("clr_r20", ifa.ReadData1, (k <= 20) ? 32'd20 : 32'd0);
      if (k == 0) chk("clr_wr_commit", ifa.ReadData2, 32'h77);
      if (k == 5) begin
        ifa.RegWrite = 1'b1; ifa.WriteRegister = 5'd31; ifa.WriteData = 32'h55;
        ifa.ReadRegister2 = 5'd31;
        #1 chk("clr_no_bypass", ifa.ReadData2, 32'd31);
      end
      if (k == 6) ifa.RegWrite = 1'b0;
      if (k == 10) ifa.Clear = 1'b1;
      if (k == 11) ifa.Clear = 1'b0;
      @(posedge Clk);
      #1 k++;
    end
    chk("clr_busy_cycles", 32'(busy_cnt), 32'd32);
    for (int i = 0; i < 32; i++) begin
      ifa.ReadRegister1 = 5'(i);
      #1 chk("clr_all_zero", ifa.ReadData1, 32'd0);
    end

    // Reset during a clear aborts it.
    wr_a(5'd25, 32'h25, 4'hF);
    @(negedge Clk) ifa.Clear = 1'b1;
    @(posedge Clk);
    #1 ifa.Clear = 1'b0;
    repeat (10) @(posedge Clk);
    #1 chk("mid_busy", {31'd0, ifa.Busy}, 32'd1);
    Reset_n = 1'b0;
    ifa.ReadRegister1 = 5'd25;
    #1 chk("rst_mid_busy", {31'd0, ifa.Busy}, 32'd0);
    chk("rst_mid_read", ifa.ReadData1, 32'd0);
    @(negedge Clk) Reset_n = 1'b1;

    // 16-bit x 8 instance, ZERO_REG=0, BYPASS=0.
    wr_b(3'd0, 16'hFFFF);
    ifb.ReadRegister1 = 3'd0;
    #1 chk("b_r0", {16'd0, ifb.ReadData1}, 32'hFFFF);
    wr_b(3'd3, 16'h0001);
    @(negedge Clk);
    ifb.WriteRegister = 3'd3; ifb.WriteData = 16'h1234; ifb.ByteEnable = 2'b11;
    ifb.RegWrite = 1'b1; ifb.ReadRegister1 = 3'd3; ifb.ReadRegister2 = 3'd3;
    #1 chk("b_nobyp_p1", {16'd0, ifb.ReadData1}, 32'h0001);
    chk("b_nobyp_p2", {16'd0, ifb.ReadData2}, 32'h0001);
    @(posedge Clk);
    #1 ifb.RegWrite = 1'b0;
    #1 chk("b_after", {16'd0, ifb.ReadData1}, 32'h1234);
    wr_b(3'd5, 16'h0005);
    @(negedge Clk) ifb.Clear = 1'b1;
    @(posedge Clk);
    #1 ifb.Clear = 1'b0;
    busy_cnt = 0;
    k = 0;
    while (ifb.Busy && k < 100) begin
      busy_cnt++;
      @(posedge Clk);
      #1 k++;
    end
    chk("b_busy_cycles", 32'(busy_cnt), 32'd8);
    ifb.ReadRegister1 = 3'd5;
    #1 chk("b_clr_r5", {16'd0, ifb.ReadData1}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/param_regfile.md
Name: param_regfile

Overview:
- Parametrised successor to the 32x32 MIPS register file, with a working write enable, per-byte write masking and optional write-to-read bypass.
- Adds a sequential bulk-clear engine that zeroes every register, one word per cycle, with a Busy handshake.
- Sits in the CPU datapath as the architectural register file: 2 async read ports, 1 sync write port.

Parameters:
- WIDTH, 32, data word width in bits; must be a multiple of 8.
- ADDR_BITS, 5, address width; DEPTH = 2**ADDR_BITS words.
- ZERO_REG, 1, 1 = register 0 reads constant zero and ignores writes; 0 = register 0 is ordinary storage.
- BYPASS, 1, 1 = a same-cycle write to a read address is forwarded to ReadData; 0 = reads show stored contents only.

Ports:
- Clk  in  1  clock, positive-edge triggered.
- Reset_n  in  1  asynchronous, active-low reset.
- ReadRegister1  in  ADDR_BITS  read port 1 address.
- ReadRegister2  in  ADDR_BITS  read port 2 address.
- ReadData1  out  WIDTH  read port 1 data (combinational).
- ReadData2  out  WIDTH  read port 2 data (combinational).
- WriteRegister  in  ADDR_BITS  write address.
- WriteData  in  WIDTH  write data.
- ByteEnable  in  WIDTH/8  per-byte write mask; bit i covers WriteData[8i+7:8i].
- RegWrite  in  1  write enable, active high.
- Clear  in  1  1-cycle pulse; starts the bulk clear when the block is idle.
- Busy  out  1  high while the bulk clear runs.

Behaviour:
- Reset (Reset_n low, async): all storage words = 0; FSM = IDLE; clear counter = 0; Busy = 0. ReadData reflects zero contents immediately.
- Reset asserted mid-clear: the clear is aborted, all words = 0, FSM = IDLE.
- Reads: asynchronous, zero latency.
  - ReadDataN = mem[ReadRegisterN].
  - ReadDataN = 0 when ZERO_REG=1 and the address is 0.
- Bypass (BYPASS=1): if RegWrite=1, Busy=0, WriteRegister==ReadRegisterN, and the address is not a masked zero register:
  - ReadDataN = per-byte merge, taking WriteData where ByteEnable=1 and mem contents elsewhere.
  - Applies to both ports independently, including when both read the same address.
- Write: at posedge Clk, when RegWrite=1 and Busy=0, mem[WriteRegister] byte i <= WriteData byte i for each ByteEnable[i]=1. Other bytes are unchanged.
  - RegWrite=0: no storage changes (the enable must be honoured).
  - ByteEnable all 0: no change.
  - Write to register 0 with ZERO_REG=1: discarded.
- Clear FSM (states IDLE, CLEARING):
  - IDLE to CLEARING: at a posedge with Clear=1. Counter <= 0; Busy goes high in the next cycle.
  - Simultaneous Clear=1 and RegWrite=1 in IDLE: the write commits at that same edge, then clearing begins and overwrites it.
  - CLEARING: each posedge sets mem[counter] <= 0 and increments counter.
  - When counter == DEPTH-1, that word is zeroed, the FSM returns to IDLE and Busy drops at the same edge.
  - Clear takes exactly DEPTH cycles with Busy=1.
  - RegWrite is ignored while Busy=1; the writer must hold off. No write is queued.
  - Clear pulses while Busy=1 are ignored (no restart).
  - Reads stay valid while clearing: already-cleared words read 0, the rest hold their old values. Bypass is disabled while Busy=1.
- Counter width = ADDR_BITS. The terminal compare ends the clear, so the counter never wraps into a second pass.

Test Plan:
- Reset and write-enable check (defaults):
  - Pulse Reset_n low -> all reads return 0x00000000 and Busy=0.
  - Write 0xDEADBEEF to r5 with RegWrite=0 -> r5 still reads 0.
  - Repeat with RegWrite=1 -> r5 reads 0xDEADBEEF after the edge.
- Byte enables:
  - r7=0x11223344, then write 0xAABBCCDD with ByteEnable=4'b0101 -> r7 = 0x11BB33DD.
- Zero register:
  - Write 0xFFFFFFFF to r0 -> r0 reads 0 (ZERO_REG=1).
  - With ZERO_REG=0, r0 reads 0xFFFFFFFF.
- Bypass:
  - r3=0x0000_0001. Same cycle: write 0x12345678 to r3 with ByteEnable=4'b1111, ReadRegister1=ReadRegister2=3 -> both ports show 0x12345678 before the edge.
  - Repeat with BYPASS=0 -> both ports show 0x00000001 until the edge.
- Bulk clear:
  - Fill r1..r31 with their index, pulse Clear -> Busy high for exactly 32 cycles.
  - Mid-clear, r20 reads 20 until cycle 20 and 0 afterwards.
  - A RegWrite of 0x55 to r31 during Busy is dropped.
  - After Busy falls, all words = 0.
- Reset mid-clear and parameter sweep:
  - Assert Reset_n at clear cycle 10 -> Busy=0 immediately, all reads 0.
  - Rerun the basic write/read test with WIDTH=16, ADDR_BITS=3 -> a clear takes 8 cycles.
